// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - UART receive FIFO with level, watermark, overflow and character timeout
module uart_rx_fifo #(
    parameter int DEPTH   = 16,
    parameter int WIDTH   = 8,
    parameter int TO_BITS = 40,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic [15:0]      cfg_div_i,
    input  logic [AW:0]      cfg_thresh_i,
    input  logic             clr_i,
    input  logic [WIDTH-1:0] rx_data_i,
    input  logic             rx_valid_i,
    output logic             rx_ready_o,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             rd_valid_o,
    input  logic             rd_ready_i,
    output logic [AW:0]      level_o,
    output logic             full_o,
    output logic             empty_o,
    output logic             thresh_o,
    output logic             ovf_o,
    input  logic             ovf_clr_i,
    output logic             timeout_o
);

    localparam int BW = $clog2(TO_BITS + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr, rptr, wptr_n, rptr_n, level_n;
    logic             push, pop, accept, thresh_n;
    logic [15:0]      div_cnt, div_n, div_max;
    logic [BW-1:0]    bit_cnt, bit_n;
    logic             timeout_n;

    assign empty_o    = (wptr == rptr);
    assign full_o     = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign level_o    = wptr - rptr;
    assign rd_valid_o = !empty_o;
    assign rd_data_o  = rd_valid_o ? mem[rptr[AW-1:0]] : '0;

    assign push   = rx_valid_i & rx_ready_o;
    assign pop    = rd_valid_o & rd_ready_i;
    // A full FIFO still accepts when the head leaves in the same cycle.
    assign accept = push & (!full_o | pop) & !clr_i;

    always_comb begin
        wptr_n = wptr;
        rptr_n = rptr;
        if (clr_i) begin
            wptr_n = '0;
            rptr_n = '0;
        end else begin
            if (accept) wptr_n = wptr + 1'b1;
            if (pop)    rptr_n = rptr + 1'b1;
        end
        level_n  = wptr_n - rptr_n;
        thresh_n = (cfg_thresh_i != '0) && (level_n >= cfg_thresh_i);
    end

    assign div_max = (cfg_div_i == 16'd0) ? 16'd1 : cfg_div_i;

    // Bit-time counter only runs while data sits untouched in the FIFO.
    always_comb begin
        div_n     = div_cnt;
        bit_n     = bit_cnt;
        timeout_n = timeout_o;
        if (clr_i || empty_o || push || pop) begin
            div_n     = '0;
            bit_n     = '0;
            timeout_n = 1'b0;
        end else begin
            if (div_cnt >= div_max - 16'd1) begin
                div_n = '0;
                if (bit_cnt != BW'(TO_BITS)) bit_n = bit_cnt + 1'b1;
            end else begin
                div_n = div_cnt + 16'd1;
            end
            if (bit_n == BW'(TO_BITS)) timeout_n = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wptr       <= '0;
            rptr       <= '0;
            rx_ready_o <= 1'b0;
            thresh_o   <= 1'b0;
            ovf_o      <= 1'b0;
            timeout_o  <= 1'b0;
            div_cnt    <= '0;
            bit_cnt    <= '0;
        end else begin
            wptr       <= wptr_n;
            rptr       <= rptr_n;
            rx_ready_o <= 1'b1;
            thresh_o   <= thresh_n;
            timeout_o  <= timeout_n;
            div_cnt    <= div_n;
            bit_cnt    <= bit_n;
            if (clr_i)
                ovf_o <= 1'b0;
            else if (push && full_o && !pop)
                ovf_o <= 1'b1;
            else if (ovf_clr_i)
                ovf_o <= 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (accept) mem[wptr[AW-1:0]] <= rx_data_i;
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - directed self-checking bench for uart_rx_fifo
module tb_uart_rx_fifo;

    logic        clk = 1'b0;
    logic        rstn;
    logic [15:0] cfg_div;
    logic [4:0]  cfg_thresh;
    logic        clr;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [7:0]  rd_data;
    logic        rd_valid;
    logic        rd_ready;
    logic [4:0]  level;
    logic        full;
    logic        empty;
    logic        thresh;
    logic        ovf;
    logic        ovf_clr;
    logic        timeout;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    uart_rx_fifo #(.DEPTH(16), .WIDTH(8), .TO_BITS(40)) dut (
        .clk_i(clk), .rstn_i(rstn), .cfg_div_i(cfg_div), .cfg_thresh_i(cfg_thresh),
        .clr_i(clr), .rx_data_i(rx_data), .rx_valid_i(rx_valid), .rx_ready_o(rx_ready),
        .rd_data_o(rd_data), .rd_valid_o(rd_valid), .rd_ready_i(rd_ready),
        .level_o(level), .full_o(full), .empty_o(empty), .thresh_o(thresh),
        .ovf_o(ovf), .ovf_clr_i(ovf_clr), .timeout_o(timeout)
    );

    // {rx_ready, rd_valid, rd_data, empty, full, level, thresh, ovf, timeout}
    localparam logic [20:0] RESET_VEC = {1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0};

    task automatic push_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk); #1;
        rx_valid = 1'b0;
    endtask

    task automatic pop_byte(output logic [7:0] b);
        b        = rd_data;
        rd_ready = 1'b1;
        @(posedge clk); #1;
        rd_ready = 1'b0;
    endtask

    task automatic test_reset;
        logic [20:0] obs;
        rstn = 1'b0; cfg_div = 16'd104; cfg_thresh = 5'd0; clr = 1'b0;
        rx_data = 8'h00; rx_valid = 1'b0; rd_ready = 1'b0; ovf_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        obs = {rx_ready, rd_valid, rd_data, empty, full, level, thresh, ovf, timeout};
        checks++;
        if (obs !== RESET_VEC) begin
            errors++; $display("FAIL reset_state: got %h expected %h", obs, RESET_VEC);
        end
        rstn = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (rx_ready !== 1'b1) begin
            errors++; $display("FAIL rx_ready_after_reset: got %b expected 1", rx_ready);
        end
    endtask

    task automatic test_order;
        logic [7:0] pat [5] = '{8'h00, 8'h00, 8'hFF, 8'h00, 8'h00};
        logic [7:0] b;
        push_byte(pat[0]);
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== 8'h00) begin
            errors++; $display("FAIL fwft_latency: got valid=%b data=%h expected valid=1 data=00", rd_valid, rd_data);
        end
        for (int i = 1; i < 5; i++) push_byte(pat[i]);
        checks++;
        if (level !== 5'd5) begin
            errors++; $display("FAIL order_level: got %0d expected 5", level);
        end
        for (int i = 0; i < 5; i++) begin
            pop_byte(b);
            checks++;
            if (b !== pat[i]) begin
                errors++; $display("FAIL order_pop%0d: got %h expected %h", i, b, pat[i]);
            end
        end
        checks++;
        if (empty !== 1'b1) begin
            errors++; $display("FAIL order_empty: got %b expected 1", empty);
        end
    endtask

    task automatic test_overflow;
        logic [7:0] b;
        for (int i = 1; i <= 16; i++) push_byte(8'(i));
        checks++;
        if (full !== 1'b1 || ovf !== 1'b0 || level !== 5'd16) begin
            errors++; $display("FAIL ovf_full: got full=%b ovf=%b level=%0d expected 1 0 16", full, ovf, level);
        end
        push_byte(8'h11);
        checks++;
        if (ovf !== 1'b1 || level !== 5'd16) begin
            errors++; $display("FAIL ovf_set: got ovf=%b level=%0d expected 1 16", ovf, level);
        end
        for (int i = 1; i <= 16; i++) begin
            pop_byte(b);
            checks++;
            if (b !== 8'(i)) begin
                errors++; $display("FAIL ovf_pop%0d: got %h expected %h", i, b, 8'(i));
            end
        end
        checks++;
        if (ovf !== 1'b1 || empty !== 1'b1) begin
            errors++; $display("FAIL ovf_sticky: got ovf=%b empty=%b expected 1 1", ovf, empty);
        end
        ovf_clr = 1'b1;
        @(posedge clk); #1;
        ovf_clr = 1'b0;
        checks++;
        if (ovf !== 1'b0) begin
            errors++; $display("FAIL ovf_clear: got %b expected 0", ovf);
        end
    endtask

    task automatic test_full_push_pop;
        logic [7:0] b;
        for (int i = 0; i < 16; i++) push_byte(8'h20 + 8'(i));
        b        = rd_data;
        rx_data  = 8'hAA;
        rx_valid = 1'b1;
        rd_ready = 1'b1;
        @(posedge clk); #1;
        rx_valid = 1'b0;
        rd_ready = 1'b0;
        checks++;
        if (ovf !== 1'b0 || level !== 5'd16 || b !== 8'h20) begin
            errors++; $display("FAIL full_pushpop: got ovf=%b level=%0d head=%h expected 0 16 20", ovf, level, b);
        end
        for (int i = 0; i < 16; i++) pop_byte(b);
        checks++;
        if (b !== 8'hAA || empty !== 1'b1) begin
            errors++; $display("FAIL full_pushpop_last: got %h empty=%b expected AA 1", b, empty);
        end
    endtask

    task automatic test_timeout(input logic [15:0] div, input int nbytes, input int exp_cyc);
        int cnt = 0;
        logic [7:0] b;
        cfg_div = div;
        for (int i = 0; i < nbytes; i++) push_byte(8'h40 + 8'(i));
        while (timeout !== 1'b1 && cnt < exp_cyc + 100) begin
            @(posedge clk); #1;
            cnt++;
        end
        checks++;
        if (cnt < exp_cyc - 1 || cnt > exp_cyc + 1) begin
            errors++; $display("FAIL timeout_delay_div%0d: got %0d cycles expected %0d", div, cnt, exp_cyc);
        end
        pop_byte(b);
        checks++;
        if (timeout !== 1'b0 || level !== 5'(nbytes - 1)) begin
            errors++; $display("FAIL timeout_pop_clear: got timeout=%b level=%0d expected 0 %0d", timeout, level, nbytes - 1);
        end
        while (rd_valid === 1'b1) pop_byte(b);
        cfg_div = 16'd104;
    endtask

    task automatic test_thresh;
        logic [7:0] b;
        cfg_thresh = 5'd4;
        for (int i = 0; i < 3; i++) push_byte(8'h60 + 8'(i));
        @(posedge clk); #1;
        checks++;
        if (thresh !== 1'b0) begin
            errors++; $display("FAIL thresh_below: got %b expected 0", thresh);
        end
        push_byte(8'h63);
        checks++;
        if (thresh !== 1'b1) begin
            errors++; $display("FAIL thresh_reach: got %b expected 1", thresh);
        end
        pop_byte(b);
        checks++;
        if (thresh !== 1'b0) begin
            errors++; $display("FAIL thresh_drop: got %b expected 0", thresh);
        end
        push_byte(8'h64);
        cfg_thresh = 5'd0;
        @(posedge clk); #1;
        checks++;
        if (thresh !== 1'b0) begin
            errors++; $display("FAIL thresh_disabled: got %b expected 0", thresh);
        end
        while (rd_valid === 1'b1) pop_byte(b);
    endtask

    task automatic test_clear_and_reset;
        logic [20:0] obs;
        for (int i = 0; i < 8; i++) push_byte(8'h80 + 8'(i));
        checks++;
        if (level !== 5'd8) begin
            errors++; $display("FAIL clr_prefill: got %0d expected 8", level);
        end
        clr      = 1'b1;
        rx_data  = 8'hEE;
        rx_valid = 1'b1;
        @(posedge clk); #1;
        clr      = 1'b0;
        rx_valid = 1'b0;
        checks++;
        if (empty !== 1'b1 || level !== 5'd0 || rd_valid !== 1'b0) begin
            errors++; $display("FAIL clr_flush: got empty=%b level=%0d valid=%b expected 1 0 0", empty, level, rd_valid);
        end
        push_byte(8'h91);
        checks++;
        if (rd_data !== 8'h91 || level !== 5'd1) begin
            errors++; $display("FAIL clr_then_push: got data=%h level=%0d expected 91 1", rd_data, level);
        end
        push_byte(8'h92);
        rx_data  = 8'h93;
        rx_valid = 1'b1;
        rstn     = 1'b0;
        #1;
        obs = {rx_ready, rd_valid, rd_data, empty, full, level, thresh, ovf, timeout};
        checks++;
        if (obs !== RESET_VEC) begin
            errors++; $display("FAIL midburst_reset: got %h expected %h", obs, RESET_VEC);
        end
        rx_valid = 1'b0;
        @(posedge clk); #1;
        rstn = 1'b1;
    endtask

    initial begin
        test_reset();
        test_order();
        test_overflow();
        test_full_push_pop();
        test_timeout(16'd104, 3, 4160);
        test_timeout(16'd0, 1, 40);
        test_thresh();
        test_clear_and_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
